// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
// Bundle of every signal exchanged between the boot loader and its
// surroundings: the framed byte stream (valid/ready), the start pulse, the
// instruction-memory byte write port and the core-reset / status outputs.
//
//   start      : one-cycle pulse, re-arms the loader from DONE or ERR
//   in_valid   : input byte valid
//   in_data    : input byte
//   in_ready   : loader can accept a byte
//   mem_we     : instruction-memory byte write enable
//   mem_addr   : instruction-memory byte address (ADDR_WIDTH bits)
//   mem_wdata  : instruction-memory write byte
//   cpu_reset  : reset to the core, high until a load completes
//   done       : load completed with correct checksum
//   error      : load failed (length or checksum)
//
// Modports: slave = loader side, master = stream source / system side.
// ---------------------------------------------------------------------------
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  start;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  cpu_reset;
    logic                  done;
    logic                  error;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error
    );
endinterface

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Receives a framed byte stream (4-byte little-endian length, payload,
// 1-byte additive checksum) and writes the payload into instruction memory
// at consecutive byte addresses from 0. The core is held in reset until a
// frame with a matching checksum has been loaded.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : imem_boot_loader_if.slave (stream in, memory write port, status)
// ---------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                clk,
    input  logic                reset,
    imem_boot_loader_if.slave   bus
);

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_LOAD = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Memory capacity in bytes, widened so a 32-bit length can be compared.
    localparam logic [32:0]         CAPACITY = 33'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q;
    logic [1:0]            hdr_cnt_q;
    // Holds the three most recent header bytes; the fourth is combined in
    // len_d on the final header beat, so the full length never needs storage.
    logic [23:0]           len_q;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            sum_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [7:0]            mem_wdata_q;
    logic                  cpu_reset_q;
    logic                  done_q;
    logic                  error_q;

    logic                  in_ready_d;
    logic                  beat_d;
    logic [31:0]           len_d;

    // Ready depends only on the state so a source can never see it change
    // in response to its own valid.
    assign in_ready_d = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CSUM);
    assign beat_d     = bus.in_valid && in_ready_d;
    // LSB-first shift: the newest byte lands at the top.
    assign len_d      = {bus.in_data, len_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_HDR;
            hdr_cnt_q   <= 2'd0;
            len_q       <= 24'd0;
            remaining_q <= '0;
            addr_q      <= '0;
            sum_q       <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                S_HDR: begin
                    if (beat_d) begin
                        len_q     <= len_d[31:8];
                        hdr_cnt_q <= hdr_cnt_q + 2'd1;
                        if (hdr_cnt_q == 2'd3) begin
                            if ({1'b0, len_d} > CAPACITY) begin
                                state_q <= S_ERR;
                                error_q <= 1'b1;
                            end else if (len_d == 32'd0) begin
                                state_q <= S_CSUM;
                            end else begin
                                remaining_q <= len_d[ADDR_WIDTH:0];
                                state_q     <= S_LOAD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (beat_d) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= bus.in_data;
                        // Wraps to 0 after a full-capacity load; nothing
                        // reads it afterwards.
                        addr_q      <= addr_q + ADDR_ONE;
                        sum_q       <= sum_q + bus.in_data;
                        remaining_q <= remaining_q - REM_ONE;
                        if (remaining_q == REM_ONE) begin
                            state_q <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (beat_d) begin
                        if (bus.in_data == sum_q) begin
                            state_q     <= S_DONE;
                            cpu_reset_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (bus.start) begin
                        state_q     <= S_HDR;
                        hdr_cnt_q   <= 2'd0;
                        len_q       <= 24'd0;
                        remaining_q <= '0;
                        addr_q      <= '0;
                        sum_q       <= 8'd0;
                        cpu_reset_q <= 1'b1;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_ERR;
                    error_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_d;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
// Drives framed byte streams into imem_boot_loader and compares the memory
// writes and final status against a frame-level model: the model decodes the
// length, derives the list of (address, byte) writes and the expected
// DONE/ERR outcome directly from the frame contents.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

    localparam int AW  = 10;
    localparam int CAP = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- write scoreboard ----------------
    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  wr_count  = 0;
    int  last_addr = -1;
    int  last_data = -1;
    wr_t mon_e;

    always @(negedge clk) begin
        if (reset === 1'b0 && bus.mem_we === 1'b1) begin
            wr_count++;
            last_addr = int'(bus.mem_addr);
            last_data = int'(bus.mem_wdata);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
                chk("wr_data", 32'(bus.mem_wdata), 32'(mon_e.data));
            end
        end
    end

    // ---------------- frame construction ----------------
    logic [7:0] fr[$];

    task automatic fr_hdr(input int unsigned len);
        fr.delete();
        fr.push_back(len[7:0]);
        fr.push_back(len[15:8]);
        fr.push_back(len[23:16]);
        fr.push_back(len[31:24]);
    endtask

    // Appends the additive checksum of the payload, optionally corrupted.
    task automatic fr_csum(input bit bad);
        int s = 0;
        for (int i = 4; i < fr.size(); i++) s = (s + int'(fr[i])) % 256;
        if (bad) s = (s + 1 + int'($urandom_range(0, 254))) % 256;
        fr.push_back(8'(s));
    endtask

    // ---------------- driver ----------------
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit rnd_start);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.start    = 1'b0;
                bus.in_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.start    = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
        chk("cpu_reset_during_load", 32'(bus.cpu_reset), 32'd1);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        @(posedge clk);
    endtask

    // Sends the frame in fr and checks the outcome against the model.
    task automatic run_frame(input string name, input bit gaps, input bit rnd_start);
        int unsigned len;
        int          nacc;
        int          nwr;
        int          s;
        bit          exp_done;
        len = {fr[3], fr[2], fr[1], fr[0]};
        exp_q.delete();
        wr_count = 0;
        if (len > CAP) begin
            nacc     = 4;
            nwr      = 0;
            exp_done = 1'b0;
        end else begin
            s = 0;
            for (int i = 0; i < int'(len); i++) begin
                wr_t e;
                e.addr = i % CAP;
                e.data = int'(fr[4+i]);
                exp_q.push_back(e);
                s = (s + e.data) % 256;
            end
            nacc     = int'(len) + 5;
            nwr      = int'(len);
            exp_done = (int'(fr[4+len]) == s);
        end
        for (int i = 0; i < nacc; i++) send_byte(fr[i], gaps, rnd_start);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        chk({name, "_done"},      32'(bus.done),      32'(exp_done));
        chk({name, "_error"},     32'(bus.error),     32'(!exp_done));
        chk({name, "_cpu_reset"}, 32'(bus.cpu_reset), 32'(!exp_done));
        chk({name, "_in_ready"},  32'(bus.in_ready),  32'd0);
        chk({name, "_writes"},    32'(wr_count),      32'(nwr));
        chk({name, "_pending"},   32'(exp_q.size()),  32'd0);
        $display("frame %s len=%0d writes=%0d done=%0b error=%0b", name, len, wr_count,
                 bus.done, bus.error);
    endtask

    task automatic pulse_start(input bit with_valid);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.in_valid = with_valid;
        bus.in_data  = 8'hFF;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        chk("rearm_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rearm_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("rearm_done",      32'(bus.done),      32'd0);
        chk("rearm_error",     32'(bus.error),     32'd0);
    endtask

    task automatic basic_frame(input logic [7:0] cs);
        fr_hdr(4);
        fr.push_back(8'h93);
        fr.push_back(8'h00);
        fr.push_back(8'h00);
        fr.push_back(8'h01);
        fr.push_back(cs);
    endtask

    logic [31:0] words[6] = '{32'h01000093, 32'h01008113, 32'h401101B3,
                              32'h00119233, 32'h0030A023, 32'h0000A283};

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("rst_done",      32'(bus.done),      32'd0);
        chk("rst_error",     32'(bus.error),     32'd0);
        chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic load, bad checksum, gapped stream.
        basic_frame(8'h94);
        run_frame("basic", 1'b0, 1'b0);
        pulse_start(1'b0);
        basic_frame(8'h95);
        run_frame("badsum", 1'b0, 1'b0);
        pulse_start(1'b0);
        basic_frame(8'h94);
        run_frame("gaps", 1'b1, 1'b0);

        // Oversize lengths: just over capacity and far over.
        pulse_start(1'b0);
        fr_hdr(32'h401);
        run_frame("oversize", 1'b0, 1'b0);
        pulse_start(1'b0);
        fr_hdr(32'h0100_0000);
        run_frame("huge", 1'b0, 1'b0);

        // Reset in the middle of a load.
        pulse_start(1'b0);
        exp_q.delete();
        begin
            wr_t e;
            e.addr = 0; e.data = 'h93; exp_q.push_back(e);
            e.addr = 1; e.data = 'h00; exp_q.push_back(e);
        end
        basic_frame(8'h94);
        for (int i = 0; i < 6; i++) send_byte(fr[i], 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("midrst_mem_we",    32'(bus.mem_we),    32'd0);
        chk("midrst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("midrst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("midrst_pending",   32'(exp_q.size()),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        basic_frame(8'h94);
        run_frame("after_reset", 1'b0, 1'b0);

        // Re-arm with start and a simultaneous (ignored) byte, 24-byte program.
        pulse_start(1'b1);
        fr_hdr(24);
        for (int w = 0; w < 6; w++)
            for (int k = 0; k < 4; k++) fr.push_back(words[w][8*k +: 8]);
        fr_csum(1'b0);
        run_frame("program24", 1'b0, 1'b0);
        chk("program24_last_addr", 32'(last_addr), 32'd23);
        chk("program24_last_data", 32'(last_data), 32'd0);

        // Empty payload: checksum must be zero.
        pulse_start(1'b0);
        fr_hdr(0);
        fr.push_back(8'h00);
        run_frame("empty_ok", 1'b0, 1'b0);
        pulse_start(1'b0);
        fr_hdr(0);
        fr.push_back(8'h5A);
        run_frame("empty_bad", 1'b0, 1'b0);

        // Exactly full capacity.
        pulse_start(1'b0);
        fr_hdr(CAP);
        for (int i = 0; i < CAP; i++) fr.push_back(8'($urandom));
        fr_csum(1'b0);
        run_frame("full", 1'b0, 1'b0);
        chk("full_last_addr", 32'(last_addr), 32'(CAP - 1));

        // Random frames with gaps, random start pulses mid-frame, some bad sums.
        for (int t = 0; t < 12; t++) begin
            int unsigned l;
            pulse_start(1'($urandom_range(0, 1)));
            l = $urandom_range(1, 40);
            fr_hdr(l);
            for (int i = 0; i < int'(l); i++) fr.push_back(8'($urandom));
            fr_csum($urandom_range(0, 3) == 0);
            run_frame($sformatf("rand%0d", t), 1'b1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
